// File: rtl/ast_pkg.sv
// rtl/ast_pkg.sv - shared types and constants for the Avalon-ST round-robin arbiter
package ast_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/ast_rr_arbiter_if.sv
// rtl/ast_rr_arbiter_if.sv - sink/source stream bundle for ast_rr_arbiter
// pkt_cnt_o exists only when AST_ARB_STATS_EN is defined.
interface ast_rr_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int WIDTH   = 32,
    parameter int CH_W    = $clog2(N_PORTS)
) ();
    import ast_pkg::*;

    logic [N_PORTS*WIDTH-1:0] snk_data_i;
    logic [N_PORTS-1:0]       snk_valid_i;
    logic [N_PORTS-1:0]       snk_sop_i;
    logic [N_PORTS-1:0]       snk_eop_i;
    logic [N_PORTS-1:0]       snk_ready_o;

    logic [WIDTH-1:0]         src_data_o;
    logic                     src_valid_o;
    logic                     src_sop_o;
    logic                     src_eop_o;
    logic [CH_W-1:0]          src_channel_o;
    logic                     src_ready_i;

`ifdef AST_ARB_STATS_EN
    logic [N_PORTS*PKT_CNT_W-1:0] pkt_cnt_o;
`endif

    modport slave (
        input  snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, src_ready_i,
        output snk_ready_o, src_data_o, src_valid_o, src_sop_o, src_eop_o,
        output src_channel_o
`ifdef AST_ARB_STATS_EN
        , output pkt_cnt_o
`endif
    );

    modport master (
        output snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, src_ready_i,
        input  snk_ready_o, src_data_o, src_valid_o, src_sop_o, src_eop_o,
        input  src_channel_o
`ifdef AST_ARB_STATS_EN
        , input pkt_cnt_o
`endif
    );

endinterface

// File: rtl/ast_rr_arbiter_rr_pick.sv
// rtl/ast_rr_arbiter_rr_pick.sv - circular priority search: first set req bit at or after ptr
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found_o && req_i[(int'(ptr_i) + i) % N]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'((int'(ptr_i) + i) % N);
            end
        end
    end

endmodule

// File: rtl/ast_rr_arbiter.sv
// rtl/ast_rr_arbiter.sv - packet-locked round-robin merge of N Avalon-ST sinks into one source
// Define AST_ARB_STATS_EN to add per-port granted-packet counters on pkt_cnt_o.
module ast_rr_arbiter
    import ast_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int WIDTH   = 32,
    parameter int CH_W    = $clog2(N_PORTS)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    ast_rr_arbiter_if.slave bus
);

    state_e          state_q, state_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] pick_idx;
    logic            pick_found;
    logic            eop_xfer;

    rr_pick #(
        .N     (N_PORTS),
        .IDX_W (CH_W)
    ) u_rr_pick (
        .req_i   (bus.snk_valid_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        rr_ptr_d          = rr_ptr_q;
        eop_xfer          = 1'b0;
        bus.src_data_o    = bus.snk_data_i[grant_q*WIDTH +: WIDTH];
        bus.src_valid_o   = 1'b0;
        bus.src_sop_o     = 1'b0;
        bus.src_eop_o     = 1'b0;
        bus.src_channel_o = grant_q;
        bus.snk_ready_o   = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                bus.src_valid_o          = bus.snk_valid_i[grant_q];
                bus.src_sop_o            = bus.snk_sop_i[grant_q];
                bus.src_eop_o            = bus.snk_eop_i[grant_q];
                bus.snk_ready_o[grant_q] = bus.src_ready_i;
                eop_xfer = bus.snk_valid_i[grant_q] & bus.src_ready_i & bus.snk_eop_i[grant_q];
                // Grant is released only by a completed eop beat; stalls and valid gaps keep it.
                if (eop_xfer) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == CH_W'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef AST_ARB_STATS_EN
    logic [PKT_CNT_W-1:0] pkt_cnt_q [N_PORTS];
    logic [PKT_CNT_W-1:0] pkt_cnt_d [N_PORTS];

    always_comb begin
        for (int k = 0; k < N_PORTS; k++) begin
            pkt_cnt_d[k] = pkt_cnt_q[k];
        end
        if (eop_xfer) begin
            pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 1'b1;
        end
    end

    always_comb begin
        bus.pkt_cnt_o = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            bus.pkt_cnt_o[k*PKT_CNT_W +: PKT_CNT_W] = pkt_cnt_q[k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_PORTS; k++) begin
                pkt_cnt_q[k] <= '0;
            end
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
`endif

endmodule

// File: doc/ast_rr_arbiter.md
AST_RR_ARBITER -- requirements
Module: ast_rr_arbiter

Interface
REQ-001 SHALL take parameter N_PORTS, default 4: number of Avalon-ST sink requesters (2..16).
REQ-002 SHALL take parameter WIDTH, default 32: beat width in bits (SYMBOLS_PER_BEAT*DATABITS_PER_SYMBOL).
REQ-003 SHALL take parameter CH_W, default $clog2(N_PORTS): channel field width.
REQ-004 SHALL provide clk_i, input, 1: single clock.
REQ-005 SHALL provide rst_i, input, 1: asynchronous active-high reset.
REQ-006 SHALL provide snk_data_i, input, N_PORTS*WIDTH: requester data, port k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL provide snk_valid_i, snk_sop_i and snk_eop_i, inputs, N_PORTS each: per-requester valid, start- and end-of-packet.
REQ-008 SHALL provide snk_ready_o, output, N_PORTS: per-requester ready.
REQ-009 SHALL provide src_data_o (WIDTH), src_valid_o (1), src_sop_o (1), src_eop_o (1) and src_channel_o (CH_W), outputs: the merged stream to the downstream FIFO write side.
REQ-010 SHALL provide src_ready_i, input, 1: downstream ready, driven by the FIFO non-full flag.

Function
REQ-011 SHALL use ready latency 0 on all ports: a beat transfers when valid and ready are both high at a clk_i edge.
REQ-012 SHALL implement two states: IDLE and LOCK.
REQ-013 In IDLE, all snk_ready_o and src_valid_o SHALL be 0.
REQ-014 In IDLE, with any snk_valid_i high, the FSM SHALL register grant g = first requester at or after rr_ptr, circularly, and enter LOCK on the next edge (arbitration costs one cycle per packet).
REQ-015 In LOCK, src_data_o/src_valid_o/src_sop_o/src_eop_o SHALL combinationally mirror requester g, src_channel_o SHALL equal g, snk_ready_o[g] SHALL equal src_ready_i, and all other snk_ready_o SHALL be 0.
REQ-016 The grant SHALL be held for the whole packet, until a beat with eop is transferred; it SHALL NOT change when requester g drops valid mid-packet or when src_ready_i is low.
REQ-017 On transfer of the eop beat, the FSM SHALL return to IDLE and set rr_ptr = (g+1) mod N_PORTS.
REQ-018 A single-beat packet (sop and eop together) SHALL follow the same rule: 1 arbitration cycle plus 1 transfer cycle.
REQ-019 The arbiter SHALL NOT check sop; a granted requester that starts without sop is passed through unchanged.
REQ-020 rr_ptr wrap SHALL be modulo N_PORTS; with N_PORTS not a power of two, rr_ptr SHALL never hold a value >= N_PORTS.

Reset
REQ-021 While rst_i is high, the state SHALL be IDLE, rr_ptr = 0, g = 0, src_valid_o = 0, snk_ready_o = 0, and src_channel_o = 0.
REQ-022 Reset asserted mid-packet SHALL abandon the packet immediately; no truncation marker is generated.

Configuration
REQ-023 With AST_ARB_STATS_EN defined, the block SHALL add output pkt_cnt_o, N_PORTS*16 bits: per-port count of packets granted, incremented on eop transfer, wrapping at 16'hFFFF->0, and cleared by reset.
REQ-024 Without AST_ARB_STATS_EN defined, pkt_cnt_o and its counters SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-025 A shared package ast_pkg SHALL hold the state enum (IDLE, LOCK) and the counter width constant PKT_CNT_W = 16.
REQ-026 The circular priority search SHALL be a sub-module rr_pick (inputs req vector and rr_ptr; output index and found flag).

Verification
REQ-027 Reset test: assert rst_i asynchronously mid-cycle -> src_valid_o = 0 and snk_ready_o = 0 immediately; after release the first grant goes to port 0.
REQ-028 Fairness test: all 4 ports continuously offer 3-beat packets -> src_channel_o sequence is 0,1,2,3,0, each with exactly 3 beats and one idle cycle between packets.
REQ-029 Backpressure test: port 2 sends a 4-beat packet while src_ready_i toggles 1,0,0,1,... -> beats appear in order with no loss or duplication, and grant stays at 2 throughout.
REQ-030 Mid-packet contention test: port 1 raises valid during port 3's packet and port 3 drops valid for 2 cycles -> grant stays at 3 until its eop, then goes to 1 (ptr 0 wraps past 3).
REQ-031 Single-beat test: port 0 sends sop = eop = 1 with data 32'hDEADBEEF -> one src beat with sop = eop = 1 and channel 0; with AST_ARB_STATS_EN, pkt_cnt_o[15:0] = 1.
REQ-032 Reset mid-packet test: assert rst_i after beat 2 of a 5-beat packet -> src_valid_o drops to 0 and the next grant after release comes from port 0.
